cajero_transaccion_param: RTL and testbench

//  Parametrised ATM transaction controller: session FSM from card insertion to card removal.

---
 rtl/cajero_pkg.sv | 21 ++
 rtl/cajero_validador_pin.sv | 58 +++++
 rtl/cajero_transaccion_param.sv | 249 ++++++++++++++++++++++++
 tb/tb_cajero_transaccion_param.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_pkg.sv
// Shared types for the ATM transaction controller: one-hot session states and
// transaction type codes.
package cajero_pkg;

   typedef enum logic [5:0] {
      S_IDLE           = 6'b000001,
      S_RECIBIENDO_PIN = 6'b000010,
      S_VALIDAR_PIN    = 6'b000100,
      S_ESPERA_TRANS   = 6'b001000,
      S_TRANSACCION    = 6'b010000,
      S_BLOQUEO        = 6'b100000
   } estado_t;

   typedef enum logic [1:0] {
      TIPO_DEPOSITO  = 2'b00,
      TIPO_RETIRO    = 2'b01,
      TIPO_CONSULTA  = 2'b10,
      TIPO_RESERVADO = 2'b11
   } tipo_t;

endpackage

// File: rtl/cajero_validador_pin.sv
// Serial PIN capture and compare, plus the wrong-attempt counter that survives
// card removal and is cleared only by a correct PIN or reset.
module cajero_validador_pin #(
   parameter int PIN_DIGITS   = 4,
   parameter int MAX_INTENTOS = 3,
   localparam int CNT_W       = $clog2(PIN_DIGITS + 1),
   localparam int INT_W       = $clog2(MAX_INTENTOS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_limpiar,
   input  logic                    i_digito_stb,
   input  logic [3:0]              i_digito,
   input  logic [4*PIN_DIGITS-1:0] i_pin_correcto,
   input  logic                    i_acierto,
   input  logic                    i_fallo,
   output logic                    o_ultimo_digito,
   output logic                    o_coincide,
   output logic                    o_agotado,
   output logic [INT_W-1:0]        o_intentos
);

   logic [4*PIN_DIGITS-1:0] r_pin;
   logic [CNT_W-1:0]        r_cnt;
   logic [INT_W-1:0]        r_intentos;
   logic [4*PIN_DIGITS+3:0] w_desplazado;

   // First-entered digit ends up in the most significant nibble.
   assign w_desplazado    = {r_pin, i_digito};
   assign o_ultimo_digito = (r_cnt == CNT_W'(PIN_DIGITS - 1));
   assign o_coincide      = (r_pin == i_pin_correcto);
   assign o_agotado       = (r_intentos == INT_W'(MAX_INTENTOS - 1));
   assign o_intentos      = r_intentos;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pin <= '0;
         r_cnt <= '0;
      end else if (i_limpiar || i_fallo) begin
         r_pin <= '0;
         r_cnt <= '0;
      end else if (i_digito_stb) begin
         r_pin <= w_desplazado[4*PIN_DIGITS-1:0];
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_intentos <= '0;
      end else if (i_acierto) begin
         r_intentos <= '0;
      end else if (i_fallo) begin
         r_intentos <= r_intentos + INT_W'(1);
      end
   end

endmodule

// File: rtl/cajero_transaccion_param.sv
// ATM session controller: card insertion, PIN entry with lockout, and a stream of
// deposit/withdraw/inquiry transactions with a per-session withdrawal limit.
module cajero_transaccion_param
   import cajero_pkg::*;
#(
   parameter int               PIN_DIGITS    = 4,
   parameter int               MAX_INTENTOS  = 3,
   parameter int               MONTO_W       = 32,
   parameter int               BALANCE_W     = 64,
   parameter logic [MONTO_W:0] LIMITE_RETIRO = (MONTO_W + 1)'(100000)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tarjeta_recibida,
   input  logic                    digito_stb,
   input  logic [3:0]              digito,
   input  logic [4*PIN_DIGITS-1:0] pin_correcto,
   input  logic                    trans_stb,
   input  logic [1:0]              tipo_trans,
   input  logic [MONTO_W-1:0]      monto,
   input  logic [BALANCE_W-1:0]    balance_inicial,
   output logic [BALANCE_W-1:0]    balance_actualizado,
   output logic                    balance_stb,
   output logic                    entregar_dinero,
   output logic                    fondos_insuficientes,
   output logic                    limite_excedido,
   output logic                    pin_incorrecto,
   output logic                    sesion_activa,
   output logic                    bloqueo,
   output estado_t                 o_dbg_estado,
   output logic [7:0]              o_dbg_intentos
);

   localparam int INT_W = $clog2(MAX_INTENTOS + 1);

   estado_t                r_estado, w_estado_sig;
   tipo_t                  r_tipo;
   logic [MONTO_W-1:0]     r_monto;
   logic [BALANCE_W-1:0]   r_balance;
   logic [MONTO_W:0]       r_acum;
   logic                   r_p_stb, r_p_ent, r_p_fondos, r_p_limite;
   logic [BALANCE_W-1:0]   r_p_bal;
   logic [BALANCE_W-1:0]   r_balance_act;
   logic                   r_balance_stb, r_entregar, r_fondos, r_limite;
   logic                   r_pin_inc, r_sesion, r_bloqueo;

   logic                   w_limpiar, w_shift, w_acierto, w_fallo, w_latch, w_ejecutar;
   logic                   w_pin_inc_sig, w_sesion_sig, w_bloqueo_sig;
   logic                   w_ultimo, w_coincide, w_agotado;
   logic [INT_W-1:0]       w_intentos;
   logic [BALANCE_W:0]     w_suma;
   logic [BALANCE_W-1:0]   w_monto_ext;
   logic [MONTO_W+1:0]     w_acum_sig;
   logic                   w_res_stb, w_res_ent, w_res_fondos, w_res_limite, w_acum_upd;
   logic [BALANCE_W-1:0]   w_res_bal;

   cajero_validador_pin #(
      .PIN_DIGITS   (PIN_DIGITS),
      .MAX_INTENTOS (MAX_INTENTOS)
   ) u_validador (
      .clk             (clk),
      .reset           (reset),
      .i_limpiar       (w_limpiar),
      .i_digito_stb    (w_shift),
      .i_digito        (digito),
      .i_pin_correcto  (pin_correcto),
      .i_acierto       (w_acierto),
      .i_fallo         (w_fallo),
      .o_ultimo_digito (w_ultimo),
      .o_coincide      (w_coincide),
      .o_agotado       (w_agotado),
      .o_intentos      (w_intentos)
   );

   always_comb begin
      w_estado_sig  = r_estado;
      w_limpiar     = 1'b0;
      w_shift       = 1'b0;
      w_acierto     = 1'b0;
      w_fallo       = 1'b0;
      w_latch       = 1'b0;
      w_ejecutar    = 1'b0;
      w_pin_inc_sig = 1'b0;
      w_sesion_sig  = r_sesion;
      w_bloqueo_sig = r_bloqueo;
      case (r_estado)
         S_IDLE: begin
            w_sesion_sig = 1'b0;
            if (tarjeta_recibida) begin
               w_limpiar    = 1'b1;
               w_estado_sig = S_RECIBIENDO_PIN;
            end
         end
         S_RECIBIENDO_PIN: begin
            if (!tarjeta_recibida) begin
               w_estado_sig = S_IDLE;
            end else if (digito_stb) begin
               w_shift = 1'b1;
               if (w_ultimo) w_estado_sig = S_VALIDAR_PIN;
            end
         end
         S_VALIDAR_PIN: begin
            if (!tarjeta_recibida) begin
               w_estado_sig = S_IDLE;
            end else if (w_coincide) begin
               w_acierto    = 1'b1;
               w_sesion_sig = 1'b1;
               w_estado_sig = S_ESPERA_TRANS;
            end else begin
               w_fallo       = 1'b1;
               w_pin_inc_sig = 1'b1;
               if (w_agotado) begin
                  w_bloqueo_sig = 1'b1;
                  w_estado_sig  = S_BLOQUEO;
               end else begin
                  w_estado_sig = S_RECIBIENDO_PIN;
               end
            end
         end
         S_ESPERA_TRANS: begin
            if (!tarjeta_recibida) begin
               w_sesion_sig = 1'b0;
               w_estado_sig = S_IDLE;
            end else if (trans_stb) begin
               w_latch      = 1'b1;
               w_estado_sig = S_TRANSACCION;
            end
         end
         S_TRANSACCION: begin
            // A transaction already latched always completes, even if the card leaves.
            w_ejecutar = 1'b1;
            if (!tarjeta_recibida) begin
               w_sesion_sig = 1'b0;
               w_estado_sig = S_IDLE;
            end else begin
               w_estado_sig = S_ESPERA_TRANS;
            end
         end
         S_BLOQUEO: begin
            w_bloqueo_sig = 1'b1;
         end
         default: begin
            w_sesion_sig = 1'b0;
            w_estado_sig = S_IDLE;
         end
      endcase
   end

   assign w_monto_ext = BALANCE_W'(r_monto);
   assign w_suma      = {1'b0, r_balance} + (BALANCE_W + 1)'(r_monto);
   assign w_acum_sig  = (MONTO_W + 2)'(r_acum) + (MONTO_W + 2)'(r_monto);

   always_comb begin
      w_res_stb    = 1'b0;
      w_res_ent    = 1'b0;
      w_res_fondos = 1'b0;
      w_res_limite = 1'b0;
      w_res_bal    = r_balance;
      w_acum_upd   = 1'b0;
      case (r_tipo)
         TIPO_DEPOSITO: begin
            if (w_suma[BALANCE_W]) begin
               w_res_limite = 1'b1;
            end else begin
               w_res_stb = 1'b1;
               w_res_bal = w_suma[BALANCE_W-1:0];
            end
         end
         TIPO_RETIRO: begin
            // Insufficient funds is reported ahead of the session limit.
            if (w_monto_ext > r_balance) begin
               w_res_fondos = 1'b1;
            end else if (w_acum_sig > (MONTO_W + 2)'(LIMITE_RETIRO)) begin
               w_res_limite = 1'b1;
            end else begin
               w_res_stb  = 1'b1;
               w_res_ent  = 1'b1;
               w_res_bal  = r_balance - w_monto_ext;
               w_acum_upd = 1'b1;
            end
         end
         TIPO_CONSULTA: begin
            w_res_stb = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado      <= S_IDLE;
         r_tipo        <= TIPO_DEPOSITO;
         r_monto       <= '0;
         r_balance     <= '0;
         r_acum        <= '0;
         r_p_stb       <= 1'b0;
         r_p_ent       <= 1'b0;
         r_p_fondos    <= 1'b0;
         r_p_limite    <= 1'b0;
         r_p_bal       <= '0;
         r_balance_act <= '0;
         r_balance_stb <= 1'b0;
         r_entregar    <= 1'b0;
         r_fondos      <= 1'b0;
         r_limite      <= 1'b0;
         r_pin_inc     <= 1'b0;
         r_sesion      <= 1'b0;
         r_bloqueo     <= 1'b0;
      end else begin
         r_estado  <= w_estado_sig;
         r_pin_inc <= w_pin_inc_sig;
         r_sesion  <= w_sesion_sig;
         r_bloqueo <= w_bloqueo_sig;
         if (w_latch) begin
            r_tipo    <= tipo_t'(tipo_trans);
            r_monto   <= monto;
            r_balance <= balance_inicial;
         end
         if (w_acierto) begin
            r_acum <= '0;
         end else if (w_ejecutar && w_acum_upd) begin
            r_acum <= w_acum_sig[MONTO_W:0];
         end
         // Results pass through one pending stage so they land two edges after trans_stb.
         r_p_stb    <= w_ejecutar && w_res_stb;
         r_p_ent    <= w_ejecutar && w_res_ent;
         r_p_fondos <= w_ejecutar && w_res_fondos;
         r_p_limite <= w_ejecutar && w_res_limite;
         if (w_ejecutar && w_res_stb) r_p_bal <= w_res_bal;
         r_balance_stb <= r_p_stb;
         r_entregar    <= r_p_ent;
         r_fondos      <= r_p_fondos;
         r_limite      <= r_p_limite;
         if (r_p_stb) r_balance_act <= r_p_bal;
      end
   end

   assign balance_actualizado  = r_balance_act;
   assign balance_stb          = r_balance_stb;
   assign entregar_dinero      = r_entregar;
   assign fondos_insuficientes = r_fondos;
   assign limite_excedido      = r_limite;
   assign pin_incorrecto       = r_pin_inc;
   assign sesion_activa        = r_sesion;
   assign bloqueo              = r_bloqueo;
   assign o_dbg_estado         = r_estado;
   assign o_dbg_intentos       = 8'(w_intentos);

endmodule

// File: tb/tb_cajero_transaccion_param.sv
// Self-checking bench for the ATM controller: a reference model pushes expected
// transaction results into a queue, and a monitor pops them as output pulses appear.
module tb_cajero_transaccion_param;
  import cajero_pkg::*;

  localparam int         BW  = 64;
  localparam int         MW  = 32;
  localparam logic [MW:0] LIM = 33'd1000;

  logic          clk;
  logic          reset;
  logic          tarjeta_recibida;
  logic          digito_stb;
  logic [3:0]    digito;
  logic [15:0]   pin_correcto;
  logic          trans_stb;
  logic [1:0]    tipo_trans;
  logic [MW-1:0] monto;
  logic [BW-1:0] balance_inicial;
  logic [BW-1:0] balance_actualizado;
  logic          balance_stb;
  logic          entregar_dinero;
  logic          fondos_insuficientes;
  logic          limite_excedido;
  logic          pin_incorrecto;
  logic          sesion_activa;
  logic          bloqueo;
  estado_t       o_dbg_estado;
  logic [7:0]    o_dbg_intentos;

  int errors = 0;
  int checks = 0;
  logic [BW+3:0] exp_q[$];
  logic [BW+3:0] mon_exp;
  logic          mon_en = 1'b0;
  longint unsigned m_acum = 0;
  logic [BW-1:0] m_bal_out = '0;

  cajero_transaccion_param #(
    .PIN_DIGITS    (4),
    .MAX_INTENTOS  (3),
    .MONTO_W       (MW),
    .BALANCE_W     (BW),
    .LIMITE_RETIRO (LIM)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .digito_stb           (digito_stb),
    .digito               (digito),
    .pin_correcto         (pin_correcto),
    .trans_stb            (trans_stb),
    .tipo_trans           (tipo_trans),
    .monto                (monto),
    .balance_inicial      (balance_inicial),
    .balance_actualizado  (balance_actualizado),
    .balance_stb          (balance_stb),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .limite_excedido      (limite_excedido),
    .pin_incorrecto       (pin_incorrecto),
    .sesion_activa        (sesion_activa),
    .bloqueo              (bloqueo),
    .o_dbg_estado         (o_dbg_estado),
    .o_dbg_intentos       (o_dbg_intentos)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && (balance_stb || entregar_dinero || fondos_insuficientes || limite_excedido)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected got stb/ent/fon/lim/bal=%b%b%b%b/%0h with nothing expected",
                 balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido, balance_actualizado);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido, balance_actualizado} !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_result got=%b%b%b%b/%0h exp=%b/%0h",
                   balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido,
                   balance_actualizado, mon_exp[BW+3:BW], mon_exp[BW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic insert_card();
    @(negedge clk);
    tarjeta_recibida = 1'b1;
    @(negedge clk);
  endtask

  task automatic remove_card();
    @(negedge clk);
    tarjeta_recibida = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the DUT in VALIDAR_PIN at the returning negedge.
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) begin
      digito_stb = 1'b1;
      digito     = p[15-4*i -: 4];
      @(negedge clk);
    end
    digito_stb = 1'b0;
  endtask

  // Drives one transaction and pushes the reference model's expected result.
  task automatic drive_trans(input logic [1:0] t, input logic [MW-1:0] m, input logic [BW-1:0] b);
    logic [BW:0] s;
    @(negedge clk);
    trans_stb       = 1'b1;
    tipo_trans      = t;
    monto           = m;
    balance_inicial = b;
    case (t)
      2'b00: begin
        s = {1'b0, b} + {{(BW-MW+1){1'b0}}, m};
        if (s[BW]) exp_q.push_back({4'b0001, m_bal_out});
        else begin
          m_bal_out = s[BW-1:0];
          exp_q.push_back({4'b1000, m_bal_out});
        end
      end
      2'b01: begin
        if ({{(BW-MW){1'b0}}, m} > b) exp_q.push_back({4'b0010, m_bal_out});
        else if (m_acum + longint'(m) > longint'(LIM)) exp_q.push_back({4'b0001, m_bal_out});
        else begin
          m_acum    = m_acum + longint'(m);
          m_bal_out = b - {{(BW-MW){1'b0}}, m};
          exp_q.push_back({4'b1100, m_bal_out});
        end
      end
      2'b10: begin
        m_bal_out = b;
        exp_q.push_back({4'b1000, m_bal_out});
      end
      default: ;
    endcase
    @(negedge clk);
    trans_stb = 1'b0;
  endtask

  task automatic open_session();
    insert_card();
    enter_pin(16'h1234);
    @(negedge clk);
    m_acum = 0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido,
         pin_incorrecto, sesion_activa, bloqueo} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bal=%0h pulses=%b%b%b%b%b levels=%b%b required all zero",
               balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes,
               limite_excedido, pin_incorrecto, sesion_activa, bloqueo);
    end
    checks++;
    if (o_dbg_estado !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", o_dbg_estado, S_IDLE);
    end
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_pin_ok();
    insert_card();
    enter_pin(16'h1234);
    checks++;
    if (sesion_activa !== 1'b0 || o_dbg_estado !== S_VALIDAR_PIN) begin
      errors++;
      $display("FAIL pin_validating got sesion=%b state=%b required 0/%b", sesion_activa, o_dbg_estado, S_VALIDAR_PIN);
    end
    @(negedge clk);
    m_acum = 0;
    checks++;
    if (sesion_activa !== 1'b1 || pin_incorrecto !== 1'b0 || o_dbg_intentos !== 8'd0) begin
      errors++;
      $display("FAIL pin_ok got sesion=%b pin_inc=%b intentos=%0d required 1/0/0",
               sesion_activa, pin_incorrecto, o_dbg_intentos);
    end
  endtask

  task automatic test_retiro();
    drive_trans(2'b01, 32'd500, 64'd1000);
    @(negedge clk);
    checks++;
    if (balance_stb !== 1'b0 || entregar_dinero !== 1'b0) begin
      errors++;
      $display("FAIL retiro_early got stb=%b ent=%b required 0/0 one cycle before", balance_stb, entregar_dinero);
    end
    @(negedge clk);
    checks++;
    if (balance_stb !== 1'b1 || entregar_dinero !== 1'b1 || balance_actualizado !== 64'd500) begin
      errors++;
      $display("FAIL retiro_ok got stb=%b ent=%b bal=%0d required 1/1/500",
               balance_stb, entregar_dinero, balance_actualizado);
    end
  endtask

  task automatic test_fondos();
    drive_trans(2'b01, 32'd1500, 64'd1000);
    repeat (2) @(negedge clk);
    checks++;
    if (fondos_insuficientes !== 1'b1 || balance_stb !== 1'b0 || entregar_dinero !== 1'b0 ||
        balance_actualizado !== 64'd500) begin
      errors++;
      $display("FAIL fondos got fon=%b stb=%b ent=%b bal=%0d required 1/0/0/500",
               fondos_insuficientes, balance_stb, entregar_dinero, balance_actualizado);
    end
  endtask

  task automatic test_varios();
    drive_trans(2'b10, 32'd0, 64'd777);
    drive_trans(2'b00, 32'd100, 64'd900);
    drive_trans(2'b00, 32'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    drive_trans(2'b11, 32'd5, 64'd50);
    repeat (2) @(negedge clk);
    checks++;
    if (o_dbg_estado !== S_ESPERA_TRANS || balance_actualizado !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL reserved_ignored got state=%b bal=%0h required %b/ffffffffffffffff",
               o_dbg_estado, balance_actualizado, S_ESPERA_TRANS);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL varios_drain got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_limite();
    remove_card();
    checks++;
    if (sesion_activa !== 1'b0 || o_dbg_estado !== S_IDLE) begin
      errors++;
      $display("FAIL card_removed got sesion=%b state=%b required 0/%b", sesion_activa, o_dbg_estado, S_IDLE);
    end
    open_session();
    drive_trans(2'b01, 32'd600, 64'd1000);
    drive_trans(2'b01, 32'd500, 64'd5000);
    repeat (2) @(negedge clk);
    checks++;
    if (limite_excedido !== 1'b1 || entregar_dinero !== 1'b0 || balance_actualizado !== 64'd400) begin
      errors++;
      $display("FAIL limite_retiro got lim=%b ent=%b bal=%0d required 1/0/400",
               limite_excedido, entregar_dinero, balance_actualizado);
    end
    drive_trans(2'b01, 32'd400, 64'd5000);
    drive_trans(2'b00, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_trans(2'b01, 32'd1, 64'd10);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL limite_drain got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    remove_card();
    open_session();
    for (int i = 0; i < 16; i++) begin
      drive_trans(2'($urandom_range(0, 3)), 32'($urandom_range(0, 300)), 64'($urandom_range(0, 2000)));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_remove();
    // Card leaves while the transaction is executing: result still issues.
    drive_trans(2'b10, 32'd0, 64'd1234);
    tarjeta_recibida = 1'b0;
    @(negedge clk);
    checks++;
    if (sesion_activa !== 1'b0 || o_dbg_estado !== S_IDLE) begin
      errors++;
      $display("FAIL remove_in_trans got sesion=%b state=%b required 0/%b", sesion_activa, o_dbg_estado, S_IDLE);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL remove_in_trans_drain got pending=%0d required 0", exp_q.size());
    end
    // Card leaves on the same cycle as trans_stb: no transaction.
    open_session();
    tarjeta_recibida = 1'b0;
    trans_stb        = 1'b1;
    tipo_trans       = 2'b01;
    monto            = 32'd10;
    balance_inicial  = 64'd100;
    @(negedge clk);
    trans_stb = 1'b0;
    checks++;
    if (o_dbg_estado !== S_IDLE || sesion_activa !== 1'b0) begin
      errors++;
      $display("FAIL remove_with_stb got state=%b sesion=%b required %b/0", o_dbg_estado, sesion_activa, S_IDLE);
    end
    repeat (4) @(negedge clk);
    // Wrong attempts accumulate across card reinsertion.
    insert_card();
    enter_pin(16'h0000);
    @(negedge clk);
    checks++;
    if (pin_incorrecto !== 1'b1 || o_dbg_intentos !== 8'd1) begin
      errors++;
      $display("FAIL wrong_pin_1 got pin_inc=%b intentos=%0d required 1/1", pin_incorrecto, o_dbg_intentos);
    end
    remove_card();
    insert_card();
    enter_pin(16'h0000);
    @(negedge clk);
    checks++;
    if (pin_incorrecto !== 1'b1 || o_dbg_intentos !== 8'd2 || bloqueo !== 1'b0) begin
      errors++;
      $display("FAIL intentos_persist got pin_inc=%b intentos=%0d bloqueo=%b required 1/2/0",
               pin_incorrecto, o_dbg_intentos, bloqueo);
    end
    enter_pin(16'h1234);
    @(negedge clk);
    m_acum = 0;
    checks++;
    if (sesion_activa !== 1'b1 || o_dbg_intentos !== 8'd0) begin
      errors++;
      $display("FAIL intentos_clear got sesion=%b intentos=%0d required 1/0", sesion_activa, o_dbg_intentos);
    end
  endtask

  task automatic test_lockout();
    remove_card();
    insert_card();
    for (int k = 1; k <= 3; k++) begin
      enter_pin(16'h0000);
      @(negedge clk);
      checks++;
      if (pin_incorrecto !== 1'b1 || bloqueo !== (k == 3)) begin
        errors++;
        $display("FAIL lockout_attempt_%0d got pin_inc=%b bloqueo=%b required 1/%b",
                 k, pin_incorrecto, bloqueo, (k == 3));
      end
    end
    enter_pin(16'h1234);
    @(negedge clk);
    trans_stb  = 1'b1;
    tipo_trans = 2'b10;
    @(negedge clk);
    trans_stb        = 1'b0;
    tarjeta_recibida = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bloqueo !== 1'b1 || sesion_activa !== 1'b0 || o_dbg_estado !== S_BLOQUEO) begin
      errors++;
      $display("FAIL lockout_hold got bloqueo=%b sesion=%b state=%b required 1/0/%b",
               bloqueo, sesion_activa, o_dbg_estado, S_BLOQUEO);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bloqueo !== 1'b0 || o_dbg_estado !== S_IDLE || o_dbg_intentos !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got bloqueo=%b state=%b intentos=%0d required 0/%b/0",
               bloqueo, o_dbg_estado, o_dbg_intentos, S_IDLE);
    end
    m_bal_out = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset            = 1'b0;
    tarjeta_recibida = 1'b0;
    digito_stb       = 1'b0;
    digito           = 4'd0;
    pin_correcto     = 16'h1234;
    trans_stb        = 1'b0;
    tipo_trans       = 2'b00;
    monto            = '0;
    balance_inicial  = '0;
    test_reset();
    test_pin_ok();
    test_retiro();
    test_fondos();
    test_varios();
    test_limite();
    test_back_to_back();
    test_remove();
    test_lockout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain got pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
